// File: rtl/video_mnist_cnn_param_ctl.sv
// Wishbone parameter controller for the video MNIST CNN pipeline: shadow registers for the
// binarizer and CNN blank-line count, transferred to the active outputs only at a frame start.
module video_mnist_cnn_param_ctl #(
  parameter int unsigned WB_ADR_WIDTH   = 8,
  parameter int unsigned WB_DAT_WIDTH   = 32,
  parameter int unsigned WB_SEL_WIDTH   = WB_DAT_WIDTH / 8,
  parameter int unsigned TUSER_WIDTH    = 1,
  parameter logic [31:0] CORE_ID        = 32'h527a_2210,
  parameter logic [31:0] CORE_VERSION   = 32'h0001_0000,
  parameter logic [7:0]  INIT_PARAM_TH  = 8'd127,
  parameter logic        INIT_PARAM_INV = 1'b0,
  parameter logic [7:0]  INIT_BLANK_NUM = 8'd3,
  parameter logic [31:0] INIT_TIMEOUT   = 32'd0
) (
  input  logic                    reset,
  input  logic                    clk,

  input  logic [WB_ADR_WIDTH-1:0] s_wb_adr_i,
  input  logic [WB_DAT_WIDTH-1:0] s_wb_dat_i,
  output logic [WB_DAT_WIDTH-1:0] s_wb_dat_o,
  input  logic                    s_wb_we_i,
  input  logic [WB_SEL_WIDTH-1:0] s_wb_sel_i,
  input  logic                    s_wb_stb_i,
  output logic                    s_wb_ack_o,

  input  logic [TUSER_WIDTH-1:0]  s_axi4s_tuser,
  input  logic                    s_axi4s_tvalid,
  input  logic                    s_axi4s_tready,

  output logic [7:0]              out_param_th,
  output logic                    out_param_inv,
  output logic [7:0]              out_param_blank_num,
  output logic                    out_update
);

  // 32-bit registers are clipped to the bus width when the bus is narrower than 32 bits.
  localparam int unsigned REG_BYTES = (WB_SEL_WIDTH < 4) ? WB_SEL_WIDTH : 4;
  localparam int unsigned REG_BITS  = REG_BYTES * 8;

  localparam logic [WB_ADR_WIDTH-1:0] ADR_CORE_ID   = WB_ADR_WIDTH'('h00);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_CORE_VER  = WB_ADR_WIDTH'('h01);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_CONTROL   = WB_ADR_WIDTH'('h04);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_STATUS    = WB_ADR_WIDTH'('h05);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_INDEX     = WB_ADR_WIDTH'('h06);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_TIMEOUT   = WB_ADR_WIDTH'('h07);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_TH        = WB_ADR_WIDTH'('h08);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_INV       = WB_ADR_WIDTH'('h09);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_BLANK     = WB_ADR_WIDTH'('h0a);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_ACT_TH    = WB_ADR_WIDTH'('h18);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_ACT_INV   = WB_ADR_WIDTH'('h19);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_ACT_BLANK = WB_ADR_WIDTH'('h1a);

  typedef enum logic {StIdle, StPending} state_e;

  state_e                  state_q, state_d;
  logic [31:0]             tcnt_q, tcnt_d;
  logic [31:0]             timeout_q, timeout_d;
  logic                    auto_q, auto_d;
  logic [WB_DAT_WIDTH-1:0] index_q, index_d;
  logic [7:0]              th_sh_q, th_sh_d;
  logic                    inv_sh_q, inv_sh_d;
  logic [7:0]              blank_sh_q, blank_sh_d;
  logic [7:0]              th_act_q, th_act_d;
  logic                    inv_act_q, inv_act_d;
  logic [7:0]              blank_act_q, blank_act_d;
  logic                    update_q;

  logic wr_en;
  logic req_wr;
  logic sof;
  logic pending;
  logic timeout_hit;
  logic apply;

  assign wr_en   = s_wb_stb_i & s_wb_we_i;
  assign req_wr  = wr_en & (s_wb_adr_i == ADR_CONTROL) & s_wb_sel_i[0] & s_wb_dat_i[0];
  assign sof     = s_axi4s_tuser[0] & s_axi4s_tvalid & s_axi4s_tready;
  assign pending = (state_q == StPending);

  assign timeout_hit = pending && (timeout_q != 32'd0) && (tcnt_q == timeout_q - 32'd1);
  assign apply       = (auto_q & sof) | (pending & (sof | timeout_hit));

  // Request/apply FSM; a request written in the apply cycle re-arms the controller.
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    unique case (state_q)
      StIdle: begin
        tcnt_d = 32'd0;
        if (req_wr) state_d = StPending;
      end
      StPending: begin
        if (apply) begin
          state_d = req_wr ? StPending : StIdle;
          tcnt_d  = 32'd0;
        end else if (tcnt_q != 32'hffff_ffff) begin
          tcnt_d = tcnt_q + 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Active registers copy the pre-write shadow values; same-cycle writes land in the shadow only.
  always_comb begin
    th_sh_d     = th_sh_q;
    inv_sh_d    = inv_sh_q;
    blank_sh_d  = blank_sh_q;
    timeout_d   = timeout_q;
    auto_d      = auto_q;
    th_act_d    = th_act_q;
    inv_act_d   = inv_act_q;
    blank_act_d = blank_act_q;
    index_d     = index_q;

    if (apply) begin
      th_act_d    = th_sh_q;
      inv_act_d   = inv_sh_q;
      blank_act_d = blank_sh_q;
      index_d     = index_q + WB_DAT_WIDTH'(1);
    end

    if (wr_en && s_wb_sel_i[0]) begin
      case (s_wb_adr_i)
        ADR_CONTROL: auto_d     = s_wb_dat_i[1];
        ADR_TH:      th_sh_d    = s_wb_dat_i[7:0];
        ADR_INV:     inv_sh_d   = s_wb_dat_i[0];
        ADR_BLANK:   blank_sh_d = s_wb_dat_i[7:0];
        default: ;
      endcase
    end

    if (wr_en && (s_wb_adr_i == ADR_TIMEOUT)) begin
      for (int unsigned i = 0; i < REG_BYTES; i++) begin
        if (s_wb_sel_i[i]) timeout_d[8*i +: 8] = s_wb_dat_i[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      tcnt_q      <= 32'd0;
      timeout_q   <= INIT_TIMEOUT;
      auto_q      <= 1'b0;
      index_q     <= '0;
      th_sh_q     <= INIT_PARAM_TH;
      inv_sh_q    <= INIT_PARAM_INV;
      blank_sh_q  <= INIT_BLANK_NUM;
      th_act_q    <= INIT_PARAM_TH;
      inv_act_q   <= INIT_PARAM_INV;
      blank_act_q <= INIT_BLANK_NUM;
      update_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      timeout_q   <= timeout_d;
      auto_q      <= auto_d;
      index_q     <= index_d;
      th_sh_q     <= th_sh_d;
      inv_sh_q    <= inv_sh_d;
      blank_sh_q  <= blank_sh_d;
      th_act_q    <= th_act_d;
      inv_act_q   <= inv_act_d;
      blank_act_q <= blank_act_d;
      update_q    <= apply;
    end
  end

  always_comb begin
    s_wb_dat_o = '0;
    case (s_wb_adr_i)
      ADR_CORE_ID:   s_wb_dat_o[REG_BITS-1:0] = CORE_ID[REG_BITS-1:0];
      ADR_CORE_VER:  s_wb_dat_o[REG_BITS-1:0] = CORE_VERSION[REG_BITS-1:0];
      ADR_CONTROL:   s_wb_dat_o[1:0]          = {auto_q, pending};
      ADR_STATUS:    s_wb_dat_o[0]            = pending;
      ADR_INDEX:     s_wb_dat_o               = index_q;
      ADR_TIMEOUT:   s_wb_dat_o[REG_BITS-1:0] = timeout_q[REG_BITS-1:0];
      ADR_TH:        s_wb_dat_o[7:0]          = th_sh_q;
      ADR_INV:       s_wb_dat_o[0]            = inv_sh_q;
      ADR_BLANK:     s_wb_dat_o[7:0]          = blank_sh_q;
      ADR_ACT_TH:    s_wb_dat_o[7:0]          = th_act_q;
      ADR_ACT_INV:   s_wb_dat_o[0]            = inv_act_q;
      ADR_ACT_BLANK: s_wb_dat_o[7:0]          = blank_act_q;
      default: ;
    endcase
  end

  assign s_wb_ack_o          = s_wb_stb_i;
  assign out_param_th        = th_act_q;
  assign out_param_inv       = inv_act_q;
  assign out_param_blank_num = blank_act_q;
  assign out_update          = update_q;

endmodule

// File: tb/tb_video_mnist_cnn_param_ctl.sv
// Scoreboard bench for video_mnist_cnn_param_ctl: directed scenarios plus random traffic,
// checked against a transaction-level model of the register map and apply rules.
module tb_video_mnist_cnn_param_ctl;

  localparam logic [31:0] CORE_ID  = 32'h527a_2210;
  localparam logic [31:0] CORE_VER = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  s_wb_adr_i = '0;
  logic [31:0] s_wb_dat_i = '0;
  logic [31:0] s_wb_dat_o;
  logic        s_wb_we_i = 1'b0;
  logic [3:0]  s_wb_sel_i = '0;
  logic        s_wb_stb_i = 1'b0;
  logic        s_wb_ack_o;
  logic [0:0]  s_axi4s_tuser = '0;
  logic        s_axi4s_tvalid = 1'b0;
  logic        s_axi4s_tready = 1'b0;
  logic [7:0]  out_param_th;
  logic        out_param_inv;
  logic [7:0]  out_param_blank_num;
  logic        out_update;

  video_mnist_cnn_param_ctl dut (
    .reset               (reset),
    .clk                 (clk),
    .s_wb_adr_i          (s_wb_adr_i),
    .s_wb_dat_i          (s_wb_dat_i),
    .s_wb_dat_o          (s_wb_dat_o),
    .s_wb_we_i           (s_wb_we_i),
    .s_wb_sel_i          (s_wb_sel_i),
    .s_wb_stb_i          (s_wb_stb_i),
    .s_wb_ack_o          (s_wb_ack_o),
    .s_axi4s_tuser       (s_axi4s_tuser),
    .s_axi4s_tvalid      (s_axi4s_tvalid),
    .s_axi4s_tready      (s_axi4s_tready),
    .out_param_th        (out_param_th),
    .out_param_inv       (out_param_inv),
    .out_param_blank_num (out_param_blank_num),
    .out_update          (out_update)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model state
  logic [7:0]  m_th, m_blank, m_ath, m_ablank;
  logic        m_inv, m_ainv, m_auto, m_pend;
  logic [31:0] m_to, m_index;
  longint      m_wait;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  th;
    logic        inv;
    logic [7:0]  blank;
  } upd_t;

  upd_t        upd_q[$];
  logic [31:0] rd_q[$];

  task automatic model_reset();
    m_th = 8'd127; m_inv = 1'b0; m_blank = 8'd3;
    m_ath = 8'd127; m_ainv = 1'b0; m_ablank = 8'd3;
    m_auto = 1'b0; m_pend = 1'b0; m_to = 32'd0; m_index = 32'd0; m_wait = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [7:0] adr);
    case (adr)
      8'h00: return CORE_ID;
      8'h01: return CORE_VER;
      8'h04: return {30'd0, m_auto, m_pend};
      8'h05: return {31'd0, m_pend};
      8'h06: return m_index;
      8'h07: return m_to;
      8'h08: return {24'd0, m_th};
      8'h09: return {31'd0, m_inv};
      8'h0a: return {24'd0, m_blank};
      8'h18: return {24'd0, m_ath};
      8'h19: return {31'd0, m_ainv};
      8'h1a: return {24'd0, m_ablank};
      default: return 32'd0;
    endcase
  endfunction

  // One bus/stream cycle: predict its effect, clock it, then compare the active outputs.
  task automatic cycle(input logic stb, input logic we, input logic [7:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel,
                       input logic tu, input logic tv, input logic tr);
    logic sof, apply, req, wr;
    upd_t u;
    s_wb_stb_i = stb; s_wb_we_i = we; s_wb_adr_i = adr; s_wb_dat_i = dat; s_wb_sel_i = sel;
    s_axi4s_tuser = tu; s_axi4s_tvalid = tv; s_axi4s_tready = tr;

    sof = tu & tv & tr;
    wr  = stb & we;
    if (stb && !we) rd_q.push_back(model_read(adr));
    apply = (m_auto && sof) ||
            (m_pend && (sof || (m_to != 0 && m_wait + 1 == longint'(m_to))));
    req = wr && adr == 8'h04 && sel[0] && dat[0];
    if (apply) begin
      u.cyc = cyc + 1; u.th = m_th; u.inv = m_inv; u.blank = m_blank;
      upd_q.push_back(u);
      m_ath = m_th; m_ainv = m_inv; m_ablank = m_blank;
      m_index = m_index + 1;
    end
    if (apply) begin
      m_pend = req; m_wait = 0;
    end else if (m_pend) begin
      m_wait++;
    end else if (req) begin
      m_pend = 1'b1; m_wait = 0;
    end
    if (wr) begin
      if (sel[0]) begin
        if (adr == 8'h04) m_auto = dat[1];
        if (adr == 8'h08) m_th = dat[7:0];
        if (adr == 8'h09) m_inv = dat[0];
        if (adr == 8'h0a) m_blank = dat[7:0];
      end
      if (adr == 8'h07)
        for (int i = 0; i < 4; i++) if (sel[i]) m_to[8*i +: 8] = dat[8*i +: 8];
    end

    @(posedge clk);
    #1;
    check("active_th", out_param_th, m_ath);
    check("active_inv", out_param_inv, m_ainv);
    check("active_blank", out_param_blank_num, m_ablank);
  endtask

  task automatic wb_wr(input logic [7:0] adr, input logic [31:0] dat);
    cycle(1'b1, 1'b1, adr, dat, 4'hf, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wb_rd(input logic [7:0] adr);
    cycle(1'b1, 1'b0, adr, 32'd0, 4'hf, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00, 32'd0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic sof_beat();
    cycle(1'b0, 1'b0, 8'h00, 32'd0, 4'h0, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic do_reset();
    s_wb_stb_i = 1'b0; s_wb_we_i = 1'b0; s_wb_sel_i = '0;
    s_axi4s_tuser = '0; s_axi4s_tvalid = 1'b0; s_axi4s_tready = 1'b0;
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_th", out_param_th, m_ath);
    check("reset_inv", out_param_inv, m_ainv);
    check("reset_blank", out_param_blank_num, m_ablank);
    check("reset_update", out_update, 1'b0);
  endtask

  // Monitor: compares read data and update pulses against the scoreboard queues.
  always @(negedge clk) begin
    if (reset) begin
      check("update_in_reset", out_update, 1'b0);
    end else begin
      if (s_wb_stb_i) check("ack", s_wb_ack_o, 1'b1);
      if (s_wb_stb_i && !s_wb_we_i) begin
        if (rd_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL read_queue: got read at 0x%0h, expected none queued", s_wb_adr_i);
        end else begin
          check($sformatf("read_0x%0h", s_wb_adr_i), s_wb_dat_o, rd_q.pop_front());
        end
      end
      while (upd_q.size() > 0 && upd_q[0].cyc < cyc) begin
        n_checks++; n_fail++;
        $display("FAIL missed_update: got no pulse, expected one at cycle %0d", upd_q[0].cyc);
        void'(upd_q.pop_front());
      end
      if (out_update) begin
        if (upd_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_update: got pulse at cycle %0d, expected none", cyc);
        end else begin
          upd_t u;
          u = upd_q.pop_front();
          check("update_cycle", 64'(cyc), 64'(u.cyc));
          check("update_th", out_param_th, u.th);
          check("update_inv", out_param_inv, u.inv);
          check("update_blank", out_param_blank_num, u.blank);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] addrs [14];
    addrs = '{8'h00, 8'h01, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0a,
              8'h18, 8'h19, 8'h1a, 8'h03, 8'h55};
    model_reset();
    #3;
    do_reset();

    // Reset state
    wb_rd(8'h18); wb_rd(8'h19); wb_rd(8'h1a); wb_rd(8'h00); wb_rd(8'h01); wb_rd(8'h05);

    // Framed update
    wb_wr(8'h08, 32'h40); wb_wr(8'h09, 32'h1); wb_wr(8'h04, 32'h1);
    wb_rd(8'h05); idle(3); sof_beat(); idle(1);
    wb_rd(8'h06); wb_rd(8'h05); wb_rd(8'h18); wb_rd(8'h19);

    // Timeout-forced apply with no video
    wb_wr(8'h07, 32'd10); wb_wr(8'h0a, 32'd5); wb_wr(8'h04, 32'h1);
    idle(14); wb_rd(8'h1a); wb_rd(8'h06); wb_wr(8'h07, 32'd0);

    // Auto mode, TH rewritten between frames
    wb_wr(8'h04, 32'h2);
    for (int i = 0; i < 3; i++) begin
      wb_wr(8'h08, 32'($urandom_range(0, 255)));
      idle(2); sof_beat(); idle(1);
    end
    wb_rd(8'h06); wb_wr(8'h04, 32'h0);

    // Shadow write collides with the sof apply cycle
    wb_wr(8'h08, 32'h11); wb_wr(8'h04, 32'h1);
    cycle(1'b1, 1'b1, 8'h08, 32'h22, 4'hf, 1'b1, 1'b1, 1'b1);
    idle(1); wb_rd(8'h18); wb_rd(8'h08);
    wb_wr(8'h04, 32'h1); sof_beat(); idle(1); wb_rd(8'h18);

    // Update request in a sof cycle while idle applies only at the next sof
    wb_wr(8'h08, 32'h33);
    cycle(1'b1, 1'b1, 8'h04, 32'h1, 4'hf, 1'b1, 1'b1, 1'b1);
    idle(3); wb_rd(8'h05); wb_rd(8'h18); sof_beat(); idle(1); wb_rd(8'h18);

    // Request in the apply cycle while pending keeps pending set
    wb_wr(8'h04, 32'h1);
    cycle(1'b1, 1'b1, 8'h04, 32'h1, 4'hf, 1'b1, 1'b1, 1'b1);
    wb_rd(8'h05); sof_beat(); wb_rd(8'h05);

    // Byte lanes and reset while pending
    wb_wr(8'h07, 32'h0);
    cycle(1'b1, 1'b1, 8'h07, 32'h1234_5678, 4'b0010, 1'b0, 1'b0, 1'b0);
    wb_rd(8'h07);
    wb_wr(8'h08, 32'h99); wb_wr(8'h04, 32'h1); idle(2);
    do_reset();
    idle(3);
    wb_rd(8'h18); wb_rd(8'h19); wb_rd(8'h1a); wb_rd(8'h05); wb_rd(8'h06); wb_rd(8'h07);
    wb_rd(8'h08); wb_rd(8'h04);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      int unsigned r;
      logic [7:0]  a;
      logic [31:0] d;
      logic        tu, tv, tr;
      r  = $urandom_range(0, 9);
      a  = addrs[$urandom_range(0, 13)];
      tu = ($urandom_range(0, 5) == 0);
      tv = ($urandom_range(0, 3) != 0);
      tr = ($urandom_range(0, 3) != 0);
      d  = (a == 8'h07) ? 32'($urandom_range(0, 24)) : $urandom;
      if (r < 3)      cycle(1'b1, 1'b0, a, 32'd0, 4'hf, tu, tv, tr);
      else if (r < 6) cycle(1'b1, 1'b1, a, d, 4'($urandom_range(0, 15)), tu, tv, tr);
      else            cycle(1'b0, 1'b0, 8'h00, 32'd0, 4'h0, tu, tv, tr);
    end

    wb_wr(8'h04, 32'h0); wb_wr(8'h07, 32'h0);
    idle(30);
    wb_rd(8'h06);
    idle(2);
    check("update_queue_drained", 64'(upd_q.size()), 64'd0);
    check("read_queue_drained", 64'(rd_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/video_mnist_cnn_param_ctl.md
Name: video_mnist_cnn_param_ctl

Overview:
- Wishbone-controlled parameter controller for the video MNIST CNN pipeline.
- Holds the binarizer threshold/invert and the CNN blank-line count as shadow registers.
- Transfers shadows to the active outputs only at a frame boundary, so downstream blocks never see a mid-frame parameter change.
- Monitors the pipeline input stream for start-of-frame beats, counts applied updates, and supports a timeout-forced apply when video stalls.

Parameters:
- WB_ADR_WIDTH, 8, Wishbone word-address width.
- WB_DAT_WIDTH, 32, Wishbone data width (>=16).
- WB_SEL_WIDTH, WB_DAT_WIDTH/8, byte-lane select width.
- TUSER_WIDTH, 1, monitored tuser width; bit0 = start of frame.
- CORE_ID, 32'h527a_2210, value returned at CORE_ID.
- CORE_VERSION, 32'h0001_0000, value returned at CORE_VERSION.
- INIT_PARAM_TH, 127, reset value of shadow and active threshold.
- INIT_PARAM_INV, 1'b0, reset value of shadow and active invert.
- INIT_BLANK_NUM, 3, reset value of shadow and active blank count.
- INIT_TIMEOUT, 0, reset value of timeout register (0 = disabled).

Ports:
- reset, in, 1: asynchronous active-high reset.
- clk, in, 1: single clock; Wishbone and stream monitor both run on it.
- s_wb_adr_i, in, WB_ADR_WIDTH: word address.
- s_wb_dat_i, in, WB_DAT_WIDTH: write data.
- s_wb_dat_o, out, WB_DAT_WIDTH: read data, combinational from address.
- s_wb_we_i, in, 1: write enable.
- s_wb_sel_i, in, WB_SEL_WIDTH: byte lanes.
- s_wb_stb_i, in, 1: strobe.
- s_wb_ack_o, out, 1: equals s_wb_stb_i; zero wait states.
- s_axi4s_tuser, in, TUSER_WIDTH: monitored pipeline input tuser.
- s_axi4s_tvalid, in, 1: monitored tvalid.
- s_axi4s_tready, in, 1: monitored tready.
- out_param_th, out, 8: active threshold.
- out_param_inv, out, 1: active invert.
- out_param_blank_num, out, 8: active blank-line count.
- out_update, out, 1: one-cycle pulse on the cycle the active registers change.

Behaviour:
- Address map (word addresses):
  - 0x00 CORE_ID, RO.
  - 0x01 CORE_VERSION, RO.
  - 0x04 CONTROL, RW. bit0 = update request (write 1 sets pending; write 0 has no effect; reads back pending). bit1 = auto mode.
  - 0x05 STATUS, RO. bit0 = pending.
  - 0x06 INDEX, RO. Apply counter, WB_DAT_WIDTH bits, wraps to 0.
  - 0x07 TIMEOUT, RW, 32 bits.
  - 0x08 TH, RW shadow [7:0].
  - 0x09 INV, RW shadow [0].
  - 0x0A BLANK_NUM, RW shadow [7:0].
  - 0x18 / 0x19 / 0x1A: RO readback of the active TH / INV / BLANK_NUM.
  - Unmapped addresses read 0 and ignore writes.
- Writes occur when s_wb_stb_i & s_wb_we_i, honour s_wb_sel_i per byte, and take effect on the next clk edge.
- Reset values:
  - Shadow and active registers = INIT_* parameters; timeout = INIT_TIMEOUT.
  - pending = 0, auto = 0, INDEX = 0, timeout counter = 0, out_update = 0.
- Frame start (sof) = s_axi4s_tuser[0] & s_axi4s_tvalid & s_axi4s_tready.
- State machine:
  - IDLE: on a CONTROL write with bit0 = 1, go to PENDING.
  - PENDING: apply on sof, or when timeout ≠ 0 and the timeout counter reaches timeout−1; then return to IDLE.
  - The timeout counter increments every cycle in PENDING, clears in IDLE and on apply, and saturates.
- Auto mode (bit1 = 1): every sof applies, regardless of state.
- Apply, registered on the next edge after the triggering cycle:
  - Active registers take the shadow values as they stood before any same-cycle write.
  - out_update = 1 for exactly one cycle, aligned with the new active values.
  - INDEX increments by 1.
  - pending clears.
- Simultaneous events:
  - Shadow write in the apply cycle: the write lands in the shadow only; active registers get the old shadow value.
  - Update-request write in a sof cycle while IDLE: the block goes to PENDING and applies at the next sof, not the current one.
  - Update-request write in the apply cycle while PENDING: pending stays set (new request wins), and the timeout counter restarts.
- Effective latency: active values change 1 clk after the sof beat. Consumers latch at the following frame start, so the new parameters govern the next whole frame.
- Reset asserted mid-PENDING: everything returns to reset values; no out_update pulse is generated.

Test Plan:
- Reset check: read 0x18/0x19/0x1A → 127/0/3; read 0x00 → CORE_ID; read 0x05 → 0; out_update = 0.
- Framed update: write TH=0x40, INV=1, CONTROL=1; STATUS reads 1 and outputs are unchanged; drive a sof beat → next cycle out_param_th=0x40, inv=1, out_update pulses 1 cycle, INDEX=1, STATUS=0.
- Timeout: TIMEOUT=10, BLANK_NUM=5, CONTROL=1 with no video → apply exactly 10 cycles after entering PENDING; out_param_blank_num=5; INDEX increments.
- Auto mode: CONTROL=2, then 3 sof beats with TH rewritten between them → each sof yields an out_update pulse with the latest TH; INDEX += 3.
- Collisions: (a) TH write in the sof apply cycle → active gets the old shadow, new value applies only at the next request; (b) CONTROL=1 in a sof cycle while IDLE → no apply until the second sof.
- Byte lanes / reset: write TIMEOUT=0x12345678 with sel=4'b0010 → reads 0x00005600 (from 0); assert reset while PENDING → all registers return to INIT values and no out_update pulse.
